// File: rtl/lc3_mem_io.sv
// lc3_mem_io: memory and memory-mapped I/O controller for the LC-3 core.
// Serves the control FSM's memory states: latches an access from MAR/MDR,
// models a fixed-latency RAM or a device-register access, then returns data
// with a one-cycle ready pulse (r). Owns KBSR/KBDR, DSR/DDR and MCR.
//
// Ports:
//   clk, reset        clock, async active-low reset
//   mio_en, r_w       access request, 1 = write
//   mar, d_in         access address, write data
//   d_out, r          read data (held until next read), ready pulse
//   kb_strobe/kb_char keyboard character input
//   dsp_valid/dsp_char/dsp_ready  display character handshake
//   kb_int            keyboard interrupt request (KBSR ready & IE)
//   run               MCR clock enable
module lc3_mem_io #(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] mar,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  output logic        r,
  input  logic        kb_strobe,
  input  logic [7:0]  kb_char,
  output logic        dsp_valid,
  output logic [7:0]  dsp_char,
  input  logic        dsp_ready,
  output logic        kb_int,
  output logic        run
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WAIT_CYCLES + 2);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

  localparam logic [15:0] DEV_BASE  = 16'hFE00;
  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  req_t          req;
  logic [15:0]   mem [DEPTH];

  logic       kbsr_rdy, kbsr_ie, dsr_rdy, dsr_ie, mcr_clk;
  logic [7:0] kbdr, ddr;

  logic        done, req_ram, ram_we, dev_we, kbdr_rd;
  logic [15:0] rd_data;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // mio_en only matters in IDLE; once started an access always completes.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mio_en) state_nxt = (mar < DEV_BASE && WAIT_CYCLES != 0) ? S_WAIT : S_DONE;
      S_WAIT:  if (cnt == CW'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / access decode ----------------
  // Everything here acts on the latched request, never on live mar/d_in.
  always_comb begin
    done    = (state == S_DONE);
    req_ram = (req.addr < DEV_BASE);
    ram_we  = done && req.wr && req_ram;
    dev_we  = done && req.wr && !req_ram;
    kbdr_rd = done && !req.wr && (req.addr == ADDR_KBDR);
    rd_data = 16'h0000;
    if (req_ram) begin
      rd_data = mem[req.addr[AW-1:0]];
    end else begin
      case (req.addr)
        ADDR_KBSR: rd_data = {kbsr_rdy, kbsr_ie, 14'h0};
        ADDR_KBDR: rd_data = {8'h00, kbdr};
        ADDR_DSR:  rd_data = {dsr_rdy, dsr_ie, 14'h0};
        ADDR_DDR:  rd_data = {8'h00, ddr};
        ADDR_MCR:  rd_data = {mcr_clk, 15'h0};
        default:   rd_data = 16'h0000;
      endcase
    end
  end

  // Request latch and wait counter. cnt counts remaining WAIT cycles; the
  // cycle that sees cnt==1 is the last one before DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      req <= '0;
    end else if (state == S_IDLE && mio_en) begin
      req.wr   <= r_w;
      req.addr <= mar;
      req.data <= d_in;
      cnt      <= CNT_INIT;
    end else if (state == S_WAIT) begin
      cnt <= cnt - CW'(1);
    end
  end

  // RAM array has no reset; an access aborted by reset never reaches DONE.
  always_ff @(posedge clk) begin
    if (ram_we) mem[req.addr[AW-1:0]] <= req.data;
  end

  // Response: r is registered from DONE, so it is high the cycle after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r     <= 1'b0;
      d_out <= 16'h0000;
    end else begin
      r <= done;
      if (done && !req.wr) d_out <= rd_data;
    end
  end

  // Keyboard: a strobe overrides a coinciding KBDR read so no char is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kbsr_rdy <= 1'b0;
      kbsr_ie  <= 1'b0;
      kbdr     <= 8'h00;
    end else begin
      if (kb_strobe) begin
        kbdr     <= kb_char;
        kbsr_rdy <= 1'b1;
      end else if (kbdr_rd) begin
        kbsr_rdy <= 1'b0;
      end
      if (dev_we && req.addr == ADDR_KBSR) kbsr_ie <= req.data[14];
    end
  end

  // Display: a DDR write wins over a coinciding handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dsr_rdy   <= 1'b1;
      dsr_ie    <= 1'b0;
      ddr       <= 8'h00;
      dsp_valid <= 1'b0;
    end else begin
      if (dev_we && req.addr == ADDR_DDR) begin
        ddr       <= req.data[7:0];
        dsp_valid <= 1'b1;
        dsr_rdy   <= 1'b0;
      end else if (dsp_valid && dsp_ready) begin
        dsp_valid <= 1'b0;
        dsr_rdy   <= 1'b1;
      end
      if (dev_we && req.addr == ADDR_DSR) dsr_ie <= req.data[14];
    end
  end

  // Machine control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          mcr_clk <= 1'b1;
    else if (dev_we && req.addr == ADDR_MCR) mcr_clk <= req.data[15];
  end

  assign dsp_char = ddr;
  assign kb_int   = kbsr_rdy & kbsr_ie;
  assign run      = mcr_clk;
endmodule

// File: tb/tb_lc3_mem_io.sv
// Testbench for lc3_mem_io: directed scenarios followed by randomized
// accesses. The stimulus side computes each access's expected data and
// ready cycle from an address-map level model and queues it; a monitor on
// the falling edge pops and compares whenever r is seen.
module tb_lc3_mem_io;
  localparam int DEPTH       = 4096;
  localparam int WAIT_CYCLES = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mio_en = 1'b0, r_w = 1'b0;
  logic [15:0] mar = 16'h0, d_in = 16'h0;
  logic [15:0] d_out;
  logic        r;
  logic        kb_strobe = 1'b0;
  logic [7:0]  kb_char = 8'h0;
  logic        dsp_valid;
  logic [7:0]  dsp_char;
  logic        dsp_ready = 1'b0;
  logic        kb_int, run;

  lc3_mem_io #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset), .mio_en(mio_en), .r_w(r_w), .mar(mar), .d_in(d_in),
    .d_out(d_out), .r(r), .kb_strobe(kb_strobe), .kb_char(kb_char),
    .dsp_valid(dsp_valid), .dsp_char(dsp_char), .dsp_ready(dsp_ready),
    .kb_int(kb_int), .run(run)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [15:0] data;
    bit          is_rd;
    int          due;
  } exp_t;
  exp_t sb[$];

  // ---------------- reference model ----------------
  logic [15:0] ram_m [int];
  bit          m_kb_rdy, m_kb_ie, m_dsp_rdy, m_dsp_ie, m_dv, m_run;
  logic [7:0]  m_kbdr, m_ddr;

  logic [15:0] pool [8] = '{16'h0000, 16'h0001, 16'h3000, 16'h3001,
                            16'hFDFF, 16'h0FFF, 16'h1000, 16'h2FFF};
  logic [15:0] dev_pool [7] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFFFE,
                                16'hFE08, 16'hFFFF, 16'hFE01};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_kb_rdy = 0; m_kb_ie = 0; m_kbdr = 8'h00;
    m_dsp_rdy = 1; m_dsp_ie = 0; m_ddr = 8'h00; m_dv = 0;
    m_run = 1;
  endtask

  task automatic m_read(input logic [15:0] a, output logic [15:0] v);
    if (a < 16'hFE00) v = ram_m[int'(a) % DEPTH];
    else begin
      case (a)
        16'hFE00: v = {m_kb_rdy, m_kb_ie, 14'h0};
        16'hFE02: begin v = {8'h00, m_kbdr}; m_kb_rdy = 0; end
        16'hFE04: v = {m_dsp_rdy, m_dsp_ie, 14'h0};
        16'hFFFE: v = {m_run, 15'h0};
        default:  v = 16'h0000;
      endcase
    end
  endtask

  task automatic m_write(input logic [15:0] a, input logic [15:0] d);
    if (a < 16'hFE00) ram_m[int'(a) % DEPTH] = d;
    else begin
      case (a)
        16'hFE00: m_kb_ie = d[14];
        16'hFE04: m_dsp_ie = d[14];
        16'hFE06: begin m_ddr = d[7:0]; m_dv = 1; m_dsp_rdy = 0; end
        16'hFFFE: m_run = d[15];
        default: ;
      endcase
    end
  endtask

  task automatic chk_side();
    chk("kb_int", kb_int, m_kb_rdy & m_kb_ie);
    chk("dsp_valid", dsp_valid, m_dv);
    chk("dsp_char", dsp_char, m_ddr);
    chk("run", run, m_run);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (r) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_r: r=1 with nothing outstanding at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("r_cycle", cyc, e.due);
          if (e.is_rd) chk("d_out", d_out, e.data);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        n_chk++; n_fail++;
        $display("FAIL r_missing: no r by cycle %0d, expected at %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers (all start on a falling edge) ----------------
  // mio_en is held for a random 1..lat+1 rising edges, so it is sometimes
  // dropped during WAIT and sometimes still high in DONE.
  task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input bit strobe = 1'b0, input logic [7:0] ch = 8'h00);
    exp_t e;
    int lat, hold, n;
    logic [15:0] v;
    lat = (a < 16'hFE00) ? WAIT_CYCLES + 1 : 1;
    v = 16'h0000;
    if (wr) m_write(a, d);
    else    m_read(a, v);
    if (strobe) begin m_kbdr = ch; m_kb_rdy = 1; end
    e.data = v; e.is_rd = !wr; e.due = cyc + 1 + lat;
    sb.push_back(e);
    mio_en = 1'b1; r_w = wr; mar = a; d_in = d;
    hold = $urandom_range(lat + 1, 1);
    n = (strobe && hold < 2) ? 2 : hold;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == hold) mio_en = 1'b0;
      if (strobe && i == 1) begin kb_strobe = 1'b1; kb_char = ch; end
      if (strobe && i == 2) kb_strobe = 1'b0;
    end
    for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL access_timeout: addr %h still outstanding at cycle %0d", a, cyc);
      sb.delete();
    end
  endtask

  task automatic kb_pulse(input logic [7:0] ch);
    kb_strobe = 1'b1; kb_char = ch;
    @(negedge clk);
    kb_strobe = 1'b0;
    m_kbdr = ch; m_kb_rdy = 1;
  endtask

  task automatic dsp_pulse();
    dsp_ready = 1'b1;
    @(negedge clk);
    dsp_ready = 1'b0;
    if (m_dv) begin m_dv = 0; m_dsp_rdy = 1; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int op;
    logic [15:0] a;
    #2 reset = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_d_out", d_out, 16'h0000);
    chk("reset_r", r, 1'b0);
    chk_side();
    reset = 1'b1;
    @(negedge clk);

    // device reset values
    access(0, 16'hFE00, 16'h0);
    access(0, 16'hFE04, 16'h0);
    access(0, 16'hFFFE, 16'h0);

    // RAM write/read and address wrap (x4000 aliases x3000 index)
    access(1, 16'h3000, 16'h1234);
    access(0, 16'h3000, 16'h0);
    access(0, 16'h4000, 16'h0);

    // keyboard
    kb_pulse(8'h41);
    chk_side();
    access(0, 16'hFE00, 16'h0);
    access(1, 16'hFE00, 16'h4000);
    chk_side();
    access(0, 16'hFE02, 16'h0);
    access(0, 16'hFE00, 16'h0);
    chk_side();

    // display
    access(1, 16'hFE06, 16'h0058);
    chk_side();
    access(0, 16'hFE04, 16'h0);
    repeat (3) @(negedge clk);
    chk_side();
    dsp_pulse();
    chk_side();
    access(0, 16'hFE04, 16'h0);

    // MCR
    access(1, 16'hFFFE, 16'h0000);
    chk_side();
    access(0, 16'hFFFE, 16'h0);
    access(1, 16'hFFFE, 16'h8000);
    chk_side();

    // unmapped device space
    access(1, 16'hFE08, 16'hFFFF);
    access(0, 16'hFE08, 16'h0);

    // KBDR read coinciding with a strobe: old data, ready stays set
    access(0, 16'hFE02, 16'h0, 1'b1, 8'h5A);
    access(0, 16'hFE00, 16'h0);
    chk_side();
    access(0, 16'hFE02, 16'h0);

    // reset in the middle of a RAM write's WAIT
    access(1, 16'h3001, 16'h0011);
    mio_en = 1'b1; r_w = 1'b1; mar = 16'h3001; d_in = 16'h00FF;
    @(negedge clk);
    mio_en = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("abort_r", r, 1'b0);
    m_reset();
    @(negedge clk);
    chk("abort_d_out", d_out, 16'h0000);
    chk_side();
    reset = 1'b1;
    repeat (10) @(negedge clk);
    access(0, 16'h3001, 16'h0);

    // randomized traffic
    for (int k = 0; k < 250; k++) begin
      op = $urandom_range(9, 0);
      case (op)
        0, 1: access(1, pool[$urandom_range(7, 0)], 16'($urandom));
        2, 3: begin
          a = pool[$urandom_range(7, 0)];
          if (ram_m.exists(int'(a) % DEPTH)) access(0, a, 16'h0);
          else access(1, a, 16'($urandom));
        end
        4: access(1'($urandom_range(1, 0)), dev_pool[$urandom_range(6, 0)], 16'($urandom));
        5: access(1, 16'hFE06, 16'($urandom));
        6: kb_pulse(8'($urandom));
        7: dsp_pulse();
        8: access(0, 16'hFE02, 16'h0, 1'b1, 8'($urandom));
        default: repeat ($urandom_range(3, 0)) @(negedge clk);
      endcase
      chk_side();
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
